// File: rtl/door_lock_if.sv
// Keypad/scene-controller bundle for the door lock controller.
// master: keypad + scene controller side; slave: door_lock_ctrl.
interface door_lock_if;
  logic [3:0] state;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_clear;
  logic       isLocked;
  logic       unlock_pulse;
  logic       err_pulse;
  logic [2:0] digit_cnt;
  logic       lockout;

  modport master (
    output state, key_valid, key_digit, key_clear,
    input  isLocked, unlock_pulse, err_pulse, digit_cnt, lockout
  );

  modport slave (
    input  state, key_valid, key_digit, key_clear,
    output isLocked, unlock_pulse, err_pulse, digit_cnt, lockout
  );
endinterface

// File: rtl/door_lock_ctrl.sv
// Per-stage door lock: collects 4 BCD digits, checks them against the
// current stage's code, drives isLocked for the door sprite and pulses
// unlock/err. Repeated wrong codes start a timed lockout.
module door_lock_ctrl #(
  parameter int unsigned STAGE1         = 2,
  parameter int unsigned STAGE2         = 4,
  parameter int unsigned STAGE3         = 6,
  parameter logic [15:0] CODE1          = 16'h1234,
  parameter logic [15:0] CODE2          = 16'h2580,
  parameter logic [15:0] CODE3          = 16'h0907,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100_000_000
) (
  input logic         clk,
  input logic         rst,
  door_lock_if.slave  bus
);

  localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);

  localparam logic [3:0] ST1 = 4'(STAGE1);
  localparam logic [3:0] ST2 = 4'(STAGE2);
  localparam logic [3:0] ST3 = 4'(STAGE3);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;

  logic [2:0]    fsm;
  logic [3:0]    prev_state;
  logic [15:0]   buffer;
  logic [2:0]    digit_cnt;
  logic [FW-1:0] fail_cnt;
  logic [TW-1:0] timer;
  logic          is_locked;
  logic          unlock_pulse;
  logic          err_pulse;
  logic          lockout;

  logic          stage_chg;
  logic          is_stage;
  logic [15:0]   stage_code;
  logic [FW-1:0] fail_next;

  // Stage decode, code lookup and saturating fail count.
  always_comb begin
    stage_chg  = (bus.state != prev_state);
    is_stage   = (bus.state == ST1) || (bus.state == ST2) || (bus.state == ST3);
    stage_code = '0;
    if (bus.state == ST1)      stage_code = CODE1;
    else if (bus.state == ST2) stage_code = CODE2;
    else if (bus.state == ST3) stage_code = CODE3;
    fail_next = (fail_cnt == FAIL_MAX) ? FAIL_MAX : fail_cnt + 1'b1;
  end

  // Lock FSM; a stage change overrides every other transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= S_IDLE;
      prev_state   <= '0;
      buffer       <= '0;
      digit_cnt    <= '0;
      fail_cnt     <= '0;
      timer        <= '0;
      is_locked    <= 1'b1;
      unlock_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      lockout      <= 1'b0;
    end else begin
      prev_state   <= bus.state;
      unlock_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      if (stage_chg) begin
        fsm       <= is_stage ? S_ENTRY : S_IDLE;
        is_locked <= 1'b1;
        buffer    <= '0;
        digit_cnt <= '0;
        fail_cnt  <= '0;
        timer     <= '0;
        lockout   <= 1'b0;
      end else begin
        case (fsm)
          S_IDLE: begin
            is_locked <= 1'b1;
          end
          S_ENTRY: begin
            if (bus.key_clear) begin
              buffer    <= '0;
              digit_cnt <= '0;
            end else if (bus.key_valid && (bus.key_digit <= 4'd9)) begin
              buffer    <= {buffer[11:0], bus.key_digit};
              digit_cnt <= digit_cnt + 3'd1;
              if (digit_cnt == 3'd3) fsm <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (buffer == stage_code) begin
              fsm          <= S_UNLOCKED;
              is_locked    <= 1'b0;
              unlock_pulse <= 1'b1;
              fail_cnt     <= '0;
            end else begin
              err_pulse <= 1'b1;
              buffer    <= '0;
              digit_cnt <= '0;
              fail_cnt  <= fail_next;
              if (fail_next == FAIL_MAX) begin
                fsm     <= S_LOCKOUT;
                lockout <= 1'b1;
                timer   <= TIMER_LOAD;
              end else begin
                fsm <= S_ENTRY;
              end
            end
          end
          S_UNLOCKED: begin
            is_locked <= 1'b0;
          end
          S_LOCKOUT: begin
            if (timer == '0) begin
              fsm      <= S_ENTRY;
              lockout  <= 1'b0;
              fail_cnt <= '0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            fsm       <= S_IDLE;
            is_locked <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.isLocked     = is_locked;
  assign bus.unlock_pulse = unlock_pulse;
  assign bus.err_pulse    = err_pulse;
  assign bus.digit_cnt    = digit_cnt;
  assign bus.lockout      = lockout;

endmodule
